iob_timer_alarm: RTL



---
 rtl/iob_timer_alarm.sv | 85 ++++++++
 1 files changed

// File: rtl/iob_timer_alarm.sv
// 64-bit alarm/compare stage: irq_o registered one cycle after time_i >= cmp_o while ARMED.
// No backpressure; cke_i=0 freezes all state, reset overrides cke_i.
module iob_timer_alarm #(
  parameter int DATA_W = 32,
  parameter int MISS_W = 8
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_n_i,
  input  logic [2*DATA_W-1:0] time_i,
  input  logic                wr_i,
  input  logic [1:0]          waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                arm_i,
  input  logic                disarm_i,
  input  logic                ack_i,
  output logic                irq_o,
  output logic [1:0]          state_o,
  output logic [MISS_W-1:0]   missed_o,
  output logic [2*DATA_W-1:0] cmp_o,
  output logic [2*DATA_W-1:0] per_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  state_t            state;
  logic [DATA_W-1:0] cmp_lo;
  logic [DATA_W-1:0] per_lo;
  logic              hit;
  logic              periodic;

  assign hit      = (state == ARMED) && (time_i >= cmp_o);
  assign periodic = (per_o != '0);
  assign state_o  = state;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      irq_o    <= 1'b0;
      missed_o <= '0;
      cmp_o    <= '1;
      per_o    <= '0;
      cmp_lo   <= '0;
      per_lo   <= '0;
    end else if (cke_i) begin
      if (wr_i && waddr_i == 2'd0) cmp_lo <= wdata_i;
      if (wr_i && waddr_i == 2'd2) per_lo <= wdata_i;
      if (wr_i && waddr_i == 2'd3) per_o <= {wdata_i, per_lo};

      // A software commit of the high word overrides a same-cycle reload.
      if (wr_i && waddr_i == 2'd1)
        cmp_o <= {wdata_i, cmp_lo};
      else if (hit && periodic)
        cmp_o <= cmp_o + per_o;

      if (disarm_i) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE:    if (arm_i) state <= ARMED;
          ARMED:   if (hit && !periodic) state <= FIRED;
          FIRED:   if (arm_i) state <= ARMED;
          default: state <= IDLE;
        endcase
      end

      if (hit)
        irq_o <= 1'b1;
      else if (ack_i)
        irq_o <= 1'b0;

      if (ack_i)
        missed_o <= '0;
      else if (hit && irq_o && missed_o != MISS_MAX)
        missed_o <= missed_o + 1'b1;
    end
  end

endmodule
